// File: rtl/cover_toggle_sched.sv
// Toggle-coverage event scheduler.
// Captures first-hit toggle points into a pending set and reports them one
// per cycle, round-robin, over a valid/ready handshake as global cover indices.
// Ports:
//   clock_i       sole clock, rising edge
//   reset_i       synchronous active-high reset
//   valid_i       per-point toggle hits, sampled every cycle
//   en_i          capture enable for valid_i
//   clear_i       pulse requesting seen/pending clear
//   out_valid_o   cover event available
//   out_ready_i   downstream accepts event
//   out_index_o   global cover index (COVER_INDEX + bit)
//   hit_count_o   distinct points loaded since reset/clear
//   all_hit_o     every point reported at least once
//   clear_busy_o  clear accepted, waiting for the held event to drain
module cover_toggle_sched #(
    parameter int unsigned WIDTH       = 36,
    parameter int unsigned COVER_INDEX = 0,
    parameter int unsigned COVER_TOTAL = 8940
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [WIDTH-1:0]             valid_i,
    input  logic                         en_i,
    input  logic                         clear_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [63:0]                  out_index_o,
    output logic [$clog2(WIDTH+1)-1:0]   hit_count_o,
    output logic                         all_hit_o,
    output logic                         clear_busy_o
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // Parameter sanity: the group must fit in the global cover space.
    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_cfg
        $error("cover_toggle_sched: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
    end

    typedef enum logic {
        ST_RUN,
        ST_CLR_WAIT
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pend_q, pend_d;
    logic [WIDTH-1:0]   seen_q, seen_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   hit_q, hit_d;
    logic               ov_q, ov_d;
    logic [63:0]        idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               all_q, all_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [WIDTH-1:0]   load_mask;
    logic [WIDTH-1:0]   cap;
    logic               hs;

    // Round-robin pick: first pending bit at or above rr_q, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (!pick_found && pend_q[IDX_W'((32'(rr_q) + k) % WIDTH)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'((32'(rr_q) + k) % WIDTH);
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        seen_d    = seen_q;
        rr_d      = rr_q;
        hit_d     = hit_q;
        ov_d      = ov_q;
        idx_d     = idx_q;
        load_mask = '0;
        cap       = en_i ? (valid_i & ~seen_q) : '0;
        hs        = ov_q && out_ready_i;

        case (state_q)
            ST_RUN: begin
                if (clear_i) begin
                    // A held event that cannot hand off this cycle must drain first.
                    if (ov_q && !out_ready_i) begin
                        state_d = ST_CLR_WAIT;
                    end else begin
                        pend_d = '0;
                        seen_d = '0;
                        rr_d   = '0;
                        hit_d  = '0;
                        ov_d   = 1'b0;
                    end
                end else begin
                    if ((!ov_q || hs) && pick_found) begin
                        load_mask = WIDTH'(1) << pick_idx;
                        seen_d    = seen_q | load_mask;
                        rr_d      = (pick_idx == IDX_W'(WIDTH - 1)) ? '0 : pick_idx + IDX_W'(1);
                        hit_d     = hit_q + CNT_W'(1);
                        ov_d      = 1'b1;
                        idx_d     = 64'(COVER_INDEX) + 64'(pick_idx);
                    end else if (hs) begin
                        ov_d = 1'b0;
                    end
                    // A hit on the bit loaded this cycle is absorbed by the load.
                    pend_d = (pend_q | cap) & ~load_mask;
                end
            end
            ST_CLR_WAIT: begin
                if (out_ready_i) begin
                    pend_d  = '0;
                    seen_d  = '0;
                    rr_d    = '0;
                    hit_d   = '0;
                    ov_d    = 1'b0;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        busy_d = (state_d == ST_CLR_WAIT);
        all_d  = &seen_d;
    end

    // State register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_RUN;
            pend_q  <= '0;
            seen_q  <= '0;
            rr_q    <= '0;
            hit_q   <= '0;
            ov_q    <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            all_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            seen_q  <= seen_d;
            rr_q    <= rr_d;
            hit_q   <= hit_d;
            ov_q    <= ov_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            all_q   <= all_d;
        end
    end

    assign out_valid_o  = ov_q;
    assign out_index_o  = idx_q;
    assign hit_count_o  = hit_q;
    assign all_hit_o    = all_q;
    assign clear_busy_o = busy_q;

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Scoreboard bench for cover_toggle_sched (WIDTH=36, COVER_INDEX=100).
module tb_cover_toggle_sched;

    localparam int W  = 36;
    localparam int CI = 100;

    logic          clock = 1'b0;
    logic          reset_i = 1'b1;
    logic [W-1:0]  valid_i = '0;
    logic          en_i = 1'b1;
    logic          clear_i = 1'b0;
    logic          out_ready_i = 1'b1;
    logic          out_valid_o;
    logic [63:0]   out_index_o;
    logic [5:0]    hit_count_o;
    logic          all_hit_o;
    logic          clear_busy_o;

    cover_toggle_sched #(.WIDTH(W), .COVER_INDEX(CI)) dut (
        .clock_i      (clock),
        .reset_i      (reset_i),
        .valid_i      (valid_i),
        .en_i         (en_i),
        .clear_i      (clear_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_index_o  (out_index_o),
        .hit_count_o  (hit_count_o),
        .all_hit_o    (all_hit_o),
        .clear_busy_o (clear_busy_o)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: sets of pending/seen points, a pointer and a held event.
    bit m_pend[W];
    bit m_seen[W];
    bit m_cap[W];
    int m_rr;
    bit m_ov;
    bit m_wait;
    int m_pick;
    int cyc = 0;
    int q_idx[$];
    int log_idx[$];
    int log_cyc[$];

    function automatic int m_hits();
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(m_seen[i]);
        return n;
    endfunction

    function automatic void m_clear_all();
        for (int i = 0; i < W; i++) begin
            m_pend[i] = 1'b0;
            m_seen[i] = 1'b0;
        end
        m_rr = 0;
        m_ov = 1'b0;
    endfunction

    always @(posedge clock) begin
        cyc++;
        if (reset_i) begin
            m_clear_all();
            m_wait = 1'b0;
            q_idx.delete();
        end else if (m_wait) begin
            if (out_ready_i) begin
                m_clear_all();
                m_wait = 1'b0;
            end
        end else if (clear_i) begin
            if (m_ov && !out_ready_i) m_wait = 1'b1;
            else m_clear_all();
        end else begin
            for (int i = 0; i < W; i++) m_cap[i] = en_i && valid_i[i] && !m_seen[i];
            m_pick = -1;
            if (!m_ov || out_ready_i) begin
                for (int k = 0; k < W; k++)
                    if (m_pick < 0 && m_pend[(m_rr + k) % W]) m_pick = (m_rr + k) % W;
            end
            if (m_pick >= 0) begin
                m_seen[m_pick] = 1'b1;
                m_rr = (m_pick + 1) % W;
                q_idx.push_back(CI + m_pick);
                m_ov = 1'b1;
            end else if (m_ov && out_ready_i) begin
                m_ov = 1'b0;
            end
            for (int i = 0; i < W; i++) m_pend[i] = (m_pend[i] || m_cap[i]) && (i != m_pick);
        end
    end

    // Monitor: compares status each cycle and pops the scoreboard on handshake.
    always @(negedge clock) begin
        chk("out_valid", longint'(out_valid_o), longint'(m_ov));
        chk("hit_count", longint'(hit_count_o), longint'(m_hits()));
        chk("all_hit", longint'(all_hit_o), longint'(m_hits() == W));
        chk("clear_busy", longint'(clear_busy_o), longint'(m_wait));
        if (out_valid_o) begin
            if (q_idx.size() == 0) begin
                chk("unexpected_event", longint'(out_index_o), -1);
            end else begin
                chk("out_index", longint'(out_index_o), longint'(q_idx[0]));
                if (out_ready_i && !reset_i) begin
                    log_idx.push_back(int'(out_index_o));
                    log_cyc.push_back(cyc);
                    void'(q_idx.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        out_ready_i = 1'b1;
        tick(3);
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        log_idx.delete();
        log_cyc.delete();
    endtask

    task automatic pulse_valid(input logic [W-1:0] v);
        valid_i = v;
        tick(1);
        valid_i = '0;
    endtask

    int t0;
    logic [W-1:0] v;

    initial begin
        // Reset state.
        tick(3);
        chk("rst_index", longint'(out_index_o), 0);
        chk("rst_valid", longint'(out_valid_o), 0);
        reset_i = 1'b0;
        tick(1);

        // Single hit, two-cycle latency.
        log_idx.delete(); log_cyc.delete();
        t0 = cyc;
        pulse_valid(W'(1) << 5);
        tick(6);
        chk("single_count", log_idx.size(), 1);
        if (log_idx.size() == 1) begin
            chk("single_idx", log_idx[0], 105);
            chk("single_lat", log_cyc[0], t0 + 2);
        end
        chk("single_hits", longint'(hit_count_o), 1);

        // Burst, round-robin from pointer 0.
        do_clear();
        v = '0; v[0] = 1'b1; v[3] = 1'b1; v[35] = 1'b1;
        pulse_valid(v);
        tick(6);
        chk("burst_count", log_idx.size(), 3);
        if (log_idx.size() == 3) begin
            chk("burst_0", log_idx[0], 100);
            chk("burst_1", log_idx[1], 103);
            chk("burst_2", log_idx[2], 135);
            chk("burst_b2b", log_cyc[2] - log_cyc[0], 2);
        end

        // Backpressure with repeated hits on the held point.
        do_clear();
        out_ready_i = 1'b0;
        pulse_valid(W'(1) << 7);
        tick(1);
        for (int i = 0; i < 10; i++) begin
            valid_i = W'(1) << 7;
            tick(1);
            chk("bp_valid", longint'(out_valid_o), 1);
            chk("bp_index", longint'(out_index_o), 107);
        end
        valid_i = '0;
        out_ready_i = 1'b1;
        tick(5);
        chk("bp_once", log_idx.size(), 1);

        // Pointer wrap.
        do_clear();
        pulse_valid(W'(1) << 33);
        tick(4);
        log_idx.delete(); log_cyc.delete();
        v = '0; v[1] = 1'b1; v[34] = 1'b1;
        pulse_valid(v);
        tick(5);
        chk("wrap_count", log_idx.size(), 2);
        if (log_idx.size() == 2) begin
            chk("wrap_0", log_idx[0], 134);
            chk("wrap_1", log_idx[1], 101);
        end

        // Clear while an event is held.
        do_clear();
        out_ready_i = 1'b0;
        pulse_valid(W'(1) << 5);
        tick(3);
        chk("clr_held", longint'(out_valid_o), 1);
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        chk("clr_busy", longint'(clear_busy_o), 1);
        chk("clr_hold_idx", longint'(out_index_o), 105);
        tick(2);
        out_ready_i = 1'b1;
        tick(1);
        chk("clr_done_busy", longint'(clear_busy_o), 0);
        chk("clr_done_hits", longint'(hit_count_o), 0);
        chk("clr_done_valid", longint'(out_valid_o), 0);
        log_idx.delete(); log_cyc.delete();
        pulse_valid(W'(1) << 5);
        tick(4);
        chk("clr_rehit_count", log_idx.size(), 1);
        if (log_idx.size() == 1) chk("clr_rehit_idx", log_idx[0], 105);

        // Full coverage, then en=0 blocks capture.
        do_clear();
        pulse_valid('1);
        tick(40);
        chk("full_count", log_idx.size(), 36);
        if (log_idx.size() == 36) begin
            chk("full_span", log_cyc[35] - log_cyc[0], 35);
            chk("full_last", log_idx[35], 135);
        end
        chk("full_all_hit", longint'(all_hit_o), 1);
        chk("full_hits", longint'(hit_count_o), 36);
        do_clear();
        en_i = 1'b0;
        valid_i = '1;
        tick(5);
        valid_i = '0;
        tick(3);
        chk("en0_count", log_idx.size(), 0);
        chk("en0_hits", longint'(hit_count_o), 0);
        en_i = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            valid_i     = W'({$urandom, $urandom} & {$urandom, $urandom} &
                             {$urandom, $urandom} & {$urandom, $urandom});
            en_i        = ($urandom_range(3) != 0);
            out_ready_i = ($urandom_range(2) != 0);
            clear_i     = ($urandom_range(63) == 0);
            reset_i     = ($urandom_range(499) == 0);
            tick(1);
        end
        valid_i = '0; clear_i = 1'b0; reset_i = 1'b0; out_ready_i = 1'b1;
        tick(60);
        chk("drain_empty", q_idx.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cover_toggle_sched.md
COVER_TOGGLE_SCHED -- requirements
Module: cover_toggle_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 36, number of toggle points in the group (1..64).
REQ-002 SHALL have parameter COVER_INDEX, default 0, global cover index of bit 0.
REQ-003 SHALL have parameter COVER_TOTAL, default 8940, total cover points; COVER_INDEX+WIDTH <= COVER_TOTAL.
REQ-004 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port valid  input  WIDTH  per-point toggle hit, sampled every cycle.
REQ-007 SHALL have port en  input  1  capture enable for valid.
REQ-008 SHALL have port clear  input  1  single-cycle pulse requesting seen/pending clear.
REQ-009 SHALL have port out_valid  output  1  reported cover event available.
REQ-010 SHALL have port out_ready  input  1  downstream reporter accepts event.
REQ-011 SHALL have port out_index  output  64  global cover index (COVER_INDEX + bit).
REQ-012 SHALL have port hit_count  output  clog2(WIDTH+1)  distinct points loaded since reset/clear.
REQ-013 SHALL have port all_hit  output  1  every point reported at least once.
REQ-014 SHALL have port clear_busy  output  1  clear request accepted, not yet completed.

Function
REQ-015 SHALL keep WIDTH-bit registers pend (captured, unreported) and seen (already loaded to output).
REQ-016 SHALL, in RUN with en=1, update pend <= (pend | (valid & ~seen)) & ~load_mask each cycle; load_mask = one-hot of bit loaded that cycle.
REQ-017 SHALL, with en=0, not capture; draining of pend continues.
REQ-018 SHALL load the output register when (!out_valid || (out_valid && out_ready)) and pend != 0, in RUN only; throughput one event per cycle.
REQ-019 SHALL select the loaded bit round-robin: first set pend bit at or above pointer rr, wrapping from WIDTH-1 to 0.
REQ-020 SHALL, on load of bit i, set seen[i], clear pend[i], set rr <= (i+1) mod WIDTH, increment hit_count, drive out_index = COVER_INDEX + i.
REQ-021 SHALL hold out_valid and out_index stable until out_valid && out_ready; out_valid deasserts after handshake if nothing is loaded.
REQ-022 SHALL give latency 2 cycles: valid[i] high in cycle t with pend empty, idle output -> out_valid=1 with that index in cycle t+2.
REQ-023 SHALL not re-capture a point once seen is set (first-hit reporting only); valid on a pending bit leaves it pending once.
REQ-024 SHALL drive all_hit = (seen == all ones) and hit_count == popcount(seen).
REQ-025 SHALL implement FSM RUN, CLR_WAIT: clear in RUN with out_valid=0 -> clear pend, seen, hit_count, rr same edge, stay RUN.
REQ-026 SHALL, on clear in RUN with out_valid=1, go to CLR_WAIT, assert clear_busy, stop capture and loads, keep output held.
REQ-027 SHALL, in CLR_WAIT on out_ready, complete the handshake, clear pend, seen, hit_count, rr, deassert out_valid and clear_busy, return to RUN.
REQ-028 SHALL ignore clear while in CLR_WAIT; clear and valid in the same RUN cycle -> clear wins, valid dropped.

Reset
REQ-029 SHALL, when reset=1 at a rising edge, set pend=0, seen=0, rr=0, hit_count=0, out_valid=0, out_index=0, clear_busy=0, state RUN; all_hit=0.
REQ-030 SHALL ignore valid, en, clear and out_ready during reset; reset mid-handshake drops the held event without report.

Verification (WIDTH=36, COVER_INDEX=100)
REQ-031 SHALL test single hit: valid=bit5 one cycle, out_ready=1 -> out_valid in t+2, out_index=105, hit_count=1, one event only.
REQ-032 SHALL test burst and round robin: valid=bits{0,3,35} one cycle, out_ready=1 -> indices 100,103,135 on consecutive cycles.
REQ-033 SHALL test backpressure: out_ready=0 for 10 cycles with bit 7 pending -> out_index=107 held stable; repeated valid[7] yields one report.
REQ-034 SHALL test wrap: rr=34 after loading bit 33, pend={1,34} -> order 134 then 101.
REQ-035 SHALL test clear with held event: out_valid=1, out_ready=0, pulse clear -> clear_busy=1; out_ready=1 -> handshake, hit_count=0, RUN, valid[5] reported again as 105.
REQ-036 SHALL test full coverage: valid=all ones, en=1, out_ready=1 -> 36 events in 36 consecutive cycles, all_hit=1, hit_count=36; en=0 blocks capture.
